bounce_count_arbiter: RTL and testbench
=======================================

Name: bounce_count_arbiter

Overview:
- Shares one internal mod-MOD up/down "bounce" counter between two requesters.
- Each requester submits a counting job: start value, initial direction and step count.
- Grants are round-robin. The granted job runs one step per clock, then the block pulses done with the final count and the requester id.
- Sits above the lab counter/register datapath as its sequencing and sharing controller.

Parameters:
MOD, 25, counter modulus; legal count values 0..MOD-1
WIDTH, 5, count/start width; must satisfy 2**WIDTH >= MOD
STEPW, 6, step-count width; max job length 2**STEPW-1 steps

Ports:
Clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req0  input  1  requester 0 job request; held high until gnt0
start0  input  WIDTH  requester 0 start value
dir0  input  1  requester 0 initial direction; 1=up, 0=down
steps0  input  STEPW  requester 0 step count
req1  input  1  requester 1 job request
start1  input  WIDTH  requester 1 start value
dir1  input  1  requester 1 initial direction
steps1  input  STEPW  requester 1 step count
gnt0  output  1  one-cycle pulse: requester 0 job accepted
gnt1  output  1  one-cycle pulse: requester 1 job accepted
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse: job complete
done_id  output  1  id of the completed job; valid with done
count_out  output  WIDTH  current counter value
dir_out  output  2  01=up, 10=down, 00=idle

Behaviour:
- Reset, asserted at any time including mid-job, forces the following immediately (async):
  - state=IDLE
  - gnt0=gnt1=busy=done=done_id=0
  - count_out=0, dir_out=00
  - round-robin pointer last=1, so requester 0 wins the first tie
  - Any in-flight job is discarded and no done is issued.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - The clock edge that samples any req high selects the winner.
    - Only one req high: that requester wins.
    - Both high: the requester != last wins, and last is updated to the winner.
  - On that edge:
    - The winner's gnt is 1 for exactly the following cycle.
    - Operands are latched.
    - count_out = start, clamped to MOD-1 if start >= MOD.
    - dir_out = 01 if dir, else 10.
    - remaining = steps.
  - Next state is RUN, or DONE directly if steps==0.
  - Requests are sampled only in IDLE. Input changes after the grant have no effect on the running job.
- RUN: each edge performs one step and decrements remaining.
  - Up, count < MOD-1: count+1.
  - Up, count == MOD-1: count = MOD-2, direction becomes down (reflect; never emits MOD).
  - Down, count > 0: count-1.
  - Down, count == 0: count = 1, direction becomes up.
  - The step taken when remaining==1 is the last; next state is DONE.
- DONE:
  - done=1 and done_id=winner for one cycle.
  - count_out and dir_out show the final values.
  - Next edge: state goes to IDLE and dir_out=00. count_out holds its last value until the next grant.
- Latency: grant edge E0, steps on E1..EN, done high in the cycle after EN, IDLE after EN+1. The next grant happens no earlier than edge EN+2.
- A req still high after its job completes is re-arbitrated. With both requesters pending, service strictly alternates.
- Degenerate case MOD==1 is not supported.

Test Plan:
1. reset pulse mid-RUN -> outputs zero immediately (asynchronous), no done pulse; next req0 grants normally with requester 0 winning any tie.
2. req0, start0=20, dir0=1, steps0=8 -> gnt0 pulse; count_out sequence 20,21,22,23,24,23,22,21,20; done=1, done_id=0, count_out=20, dir_out=10.
3. req1, start1=2, dir1=0, steps1=5 -> count_out sequence 2,1,0,1,2,3; done with done_id=1, count_out=3, dir_out=01.
4. req0 and req1 raised together, both with steps=3 and held high -> gnt0 first, done_id=0; then gnt1, done_id=1; then gnt0 again (alternation); gnt is never asserted during busy.
5. req0, start0=7, steps0=0 -> gnt0, then done in the next cycle with count_out=7. A separate job with start0=30, dir0=1, steps0=1 -> count clamps to 24, then reflects to 23, dir_out=10.

Source files
------------

// File: rtl/bounce_count_arbiter_if.sv
// Job request / grant / status bundle for bounce_count_arbiter.
// master drives requests and operands, slave returns grants and counter state.
interface bounce_count_arbiter_if #(
    parameter int WIDTH = 5,
    parameter int STEPW = 6
);
    logic             req0;
    logic [WIDTH-1:0] start0;
    logic             dir0;
    logic [STEPW-1:0] steps0;
    logic             req1;
    logic [WIDTH-1:0] start1;
    logic             dir1;
    logic [STEPW-1:0] steps1;
    logic             gnt0;
    logic             gnt1;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] count_out;
    logic [1:0]       dir_out;

    modport master (
        output req0, start0, dir0, steps0,
        output req1, start1, dir1, steps1,
        input  gnt0, gnt1, busy, done, done_id, count_out, dir_out
    );

    modport slave (
        input  req0, start0, dir0, steps0,
        input  req1, start1, dir1, steps1,
        output gnt0, gnt1, busy, done, done_id, count_out, dir_out
    );
endinterface

// File: rtl/bounce_count_arbiter.sv
// Round-robin sharing of one mod-MOD up/down bounce counter between two
// requesters; the granted job advances one step per clock, then reports done.
module bounce_count_arbiter #(
    parameter int MOD   = 25,
    parameter int WIDTH = 5,
    parameter int STEPW = 6
) (
    input logic                   Clk,
    input logic                   reset,
    bounce_count_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [WIDTH-1:0] TOP    = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] TOP_M1 = WIDTH'(MOD - 2);
    localparam logic [1:0]       UP     = 2'b01;
    localparam logic [1:0]       DN     = 2'b10;
    localparam logic [1:0]       OFF    = 2'b00;

    state_t           state, state_n;
    logic             gnt0, gnt0_n, gnt1, gnt1_n;
    logic             busy, busy_n, done, done_n;
    logic             done_id, done_id_n;
    logic             id, id_n, last, last_n;
    logic [WIDTH-1:0] count, count_n, sel_start;
    logic [1:0]       dir, dir_n;
    logic [STEPW-1:0] rem, rem_n, sel_steps;
    logic             win, sel_dir;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            id      <= 1'b0;
            last    <= 1'b1;
            count   <= '0;
            dir     <= OFF;
            rem     <= '0;
        end else begin
            state   <= state_n;
            gnt0    <= gnt0_n;
            gnt1    <= gnt1_n;
            busy    <= busy_n;
            done    <= done_n;
            done_id <= done_id_n;
            id      <= id_n;
            last    <= last_n;
            count   <= count_n;
            dir     <= dir_n;
            rem     <= rem_n;
        end
    end

    always_comb begin
        // on a tie the requester not served last wins
        win       = bus.req1 && (!bus.req0 || !last);
        sel_start = win ? bus.start1 : bus.start0;
        sel_dir   = win ? bus.dir1   : bus.dir0;
        sel_steps = win ? bus.steps1 : bus.steps0;

        state_n   = state;
        gnt0_n    = 1'b0;
        gnt1_n    = 1'b0;
        busy_n    = busy;
        done_n    = 1'b0;
        done_id_n = done_id;
        id_n      = id;
        last_n    = last;
        count_n   = count;
        dir_n     = dir;
        rem_n     = rem;

        unique case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    if (bus.req0 && bus.req1)
                        last_n = win;
                    id_n    = win;
                    gnt0_n  = !win;
                    gnt1_n  = win;
                    busy_n  = 1'b1;
                    count_n = (sel_start > TOP) ? TOP : sel_start;
                    dir_n   = sel_dir ? UP : DN;
                    rem_n   = sel_steps;
                    if (sel_steps == '0) begin
                        state_n   = DONE;
                        done_n    = 1'b1;
                        done_id_n = win;
                    end else begin
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                // reflect at both ends so MOD itself is never emitted
                if (dir == UP) begin
                    if (count == TOP) begin
                        count_n = TOP_M1;
                        dir_n   = DN;
                    end else begin
                        count_n = count + WIDTH'(1);
                    end
                end else begin
                    if (count == '0) begin
                        count_n = WIDTH'(1);
                        dir_n   = UP;
                    end else begin
                        count_n = count - WIDTH'(1);
                    end
                end
                rem_n = rem - STEPW'(1);
                if (rem == STEPW'(1)) begin
                    state_n   = DONE;
                    done_n    = 1'b1;
                    done_id_n = id;
                end
            end
            DONE: begin
                state_n = IDLE;
                dir_n   = OFF;
                busy_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.done_id   = done_id;
    assign bus.count_out = count;
    assign bus.dir_out   = dir;
endmodule

// File: tb/tb_bounce_count_arbiter.sv
// Bench for bounce_count_arbiter: vector table, hand sequences, and random
// jobs checked against a reflection-unfolding reference model.
module tb_bounce_count_arbiter;
    localparam int MOD   = 25;
    localparam int WIDTH = 5;
    localparam int STEPW = 6;

    logic Clk;
    logic reset;
    int   ncmp;
    int   nerr;
    int   gnt_bad;
    int   model_last;
    logic prev_busy;

    bounce_count_arbiter_if #(.WIDTH(WIDTH), .STEPW(STEPW)) bus ();

    bounce_count_arbiter #(.MOD(MOD), .WIDTH(WIDTH), .STEPW(STEPW)) dut (
        .Clk  (Clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct {
        int who;
        int st;
        int d;
        int n;
        int fc;
        int fd;
    } vec_t;

    vec_t tbl[7];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // a grant may only appear when the previous cycle was not busy
    initial begin
        gnt_bad   = 0;
        prev_busy = 1'b0;
    end
    always @(negedge Clk) begin
        if ((bus.gnt0 || bus.gnt1) && prev_busy)
            gnt_bad++;
        if (bus.gnt0 && bus.gnt1)
            gnt_bad++;
        prev_busy = bus.busy;
    end

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Count sequence unfolded onto a circle of length 2*(MOD-1):
    // phase 0..MOD-1 is the rising leg, the rest the falling leg.
    function automatic void model(input int s, input int up, input int n,
                                  output int c, output int dcode);
        int per;
        int p;
        per = 2 * (MOD - 1);
        if (n == 0) begin
            c     = s;
            dcode = up ? 1 : 2;
            return;
        end
        p = up ? s : (per - s) % per;
        p = (p + n) % per;
        c = (p <= MOD - 1) ? p : per - p;
        dcode = (p >= 1 && p <= MOD - 1) ? 1 : 2;
    endfunction

    task automatic set_ops(input int who, input int st, input int d,
                           input int n, input bit rq);
        if (who == 0) begin
            bus.start0 = WIDTH'(st);
            bus.dir0   = d[0];
            bus.steps0 = STEPW'(n);
            bus.req0   = rq;
        end else begin
            bus.start1 = WIDTH'(st);
            bus.dir1   = d[0];
            bus.steps1 = STEPW'(n);
            bus.req1   = rq;
        end
    endtask

    task automatic run_one(input int who, input int st, input int d,
                           input int n, input int fc, input int fd);
        bit seen;
        int cl;
        int c;
        int dd;
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge Clk);
            if (bus.gnt0 || bus.gnt1)
                seen = 1;
        end
        chk("grant_seen", int'(seen), 1);
        if (!seen)
            return;
        chk("grant_id", bus.gnt1 ? 1 : 0, who);
        // scramble the winner's operands; the job must not notice
        set_ops(who, $urandom_range(0, 31), $urandom_range(0, 1),
                $urandom_range(0, 63), 1'b0);
        cl = (st > MOD - 1) ? MOD - 1 : st;
        chk("load_count", int'(bus.count_out), cl);
        chk("load_dir", int'(bus.dir_out), d ? 1 : 2);
        chk("busy_run", int'(bus.busy), 1);
        for (int k = 1; k <= n; k++) begin
            @(negedge Clk);
            model(cl, d, k, c, dd);
            chk("step_count", int'(bus.count_out), c);
            if (k < n)
                chk("early_done", int'(bus.done), 0);
        end
        chk("done", int'(bus.done), 1);
        chk("done_id", int'(bus.done_id), who);
        chk("final_count", int'(bus.count_out), fc);
        chk("final_dir", int'(bus.dir_out), fd);
        @(negedge Clk);
        chk("idle_busy", int'(bus.busy), 0);
        chk("idle_dir", int'(bus.dir_out), 0);
        chk("idle_count", int'(bus.count_out), fc);
        chk("idle_done", int'(bus.done), 0);
    endtask

    task automatic job(input int who, input int st, input int d, input int n);
        int cl;
        int c;
        int dd;
        cl = (st > MOD - 1) ? MOD - 1 : st;
        model(cl, d, n, c, dd);
        run_one(who, st, d, n, c, dd);
    endtask

    initial begin
        int order[$];
        int dids[$];
        int ndone;
        int mode;
        int w;
        int s0, d0, n0, s1, d1, n1;

        ncmp = 0;
        nerr = 0;
        tbl[0] = '{0, 20, 1, 8, 20, 2};
        tbl[1] = '{1, 2, 0, 5, 3, 1};
        tbl[2] = '{0, 7, 1, 0, 7, 1};
        tbl[3] = '{0, 30, 1, 1, 23, 2};
        tbl[4] = '{1, 24, 0, 2, 22, 2};
        tbl[5] = '{0, 0, 1, 3, 3, 1};
        tbl[6] = '{1, 0, 0, 1, 1, 1};

        reset = 1'b1;
        set_ops(0, 0, 0, 0, 1'b0);
        set_ops(1, 0, 0, 0, 1'b0);
        model_last = 1;
        @(negedge Clk);
        @(negedge Clk);
        chk("rst_count", int'(bus.count_out), 0);
        chk("rst_dir", int'(bus.dir_out), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_done_id", int'(bus.done_id), 0);
        chk("rst_gnt", int'({bus.gnt1, bus.gnt0}), 0);
        reset = 1'b0;
        @(negedge Clk);

        foreach (tbl[i]) begin
            set_ops(tbl[i].who, tbl[i].st, tbl[i].d, tbl[i].n, 1'b1);
            run_one(tbl[i].who, tbl[i].st, tbl[i].d, tbl[i].n,
                    tbl[i].fc, tbl[i].fd);
        end

        // both held high: service must alternate 0,1,0,1
        set_ops(0, 10, 1, 3, 1'b1);
        set_ops(1, 3, 0, 3, 1'b1);
        for (int t = 0; t < 60 && order.size() < 4; t++) begin
            @(negedge Clk);
            if (bus.gnt0) order.push_back(0);
            if (bus.gnt1) order.push_back(1);
            if (bus.done) dids.push_back(int'(bus.done_id));
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        for (int t = 0; t < 12; t++) begin
            @(negedge Clk);
            if (bus.done) dids.push_back(int'(bus.done_id));
        end
        chk("alt_grants", order.size(), 4);
        chk("alt_dones", dids.size(), 4);
        foreach (order[i]) chk("alt_order", order[i], i % 2);
        foreach (dids[i]) chk("alt_done_id", dids[i], i % 2);
        model_last = 1;

        // asynchronous reset in the middle of a long job
        set_ops(0, 5, 1, 20, 1'b1);
        for (int t = 0; t < 10 && !bus.gnt0; t++) @(negedge Clk);
        bus.req0 = 1'b0;
        repeat (3) @(negedge Clk);
        #1 reset = 1'b1;
        #1;
        chk("arst_count", int'(bus.count_out), 0);
        chk("arst_dir", int'(bus.dir_out), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_done", int'(bus.done), 0);
        @(negedge Clk);
        @(negedge Clk);
        reset = 1'b0;
        model_last = 1;
        ndone = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge Clk);
            if (bus.done) ndone++;
        end
        chk("arst_no_done", ndone, 0);

        // tie after reset: requester 0 first
        set_ops(0, 12, 0, 4, 1'b1);
        set_ops(1, 19, 1, 9, 1'b1);
        model_last = 0;
        job(0, 12, 0, 4);
        job(1, 19, 1, 9);

        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 2);
            s0 = $urandom_range(0, 31);
            d0 = $urandom_range(0, 1);
            n0 = $urandom_range(0, 63);
            s1 = $urandom_range(0, 31);
            d1 = $urandom_range(0, 1);
            n1 = $urandom_range(0, 63);
            if (mode == 2) begin
                set_ops(0, s0, d0, n0, 1'b1);
                set_ops(1, s1, d1, n1, 1'b1);
                w = (model_last == 1) ? 0 : 1;
                model_last = w;
                if (w == 0) begin
                    job(0, s0, d0, n0);
                    job(1, s1, d1, n1);
                end else begin
                    job(1, s1, d1, n1);
                    job(0, s0, d0, n0);
                end
            end else if (mode == 0) begin
                set_ops(0, s0, d0, n0, 1'b1);
                job(0, s0, d0, n0);
            end else begin
                set_ops(1, s1, d1, n1, 1'b1);
                job(1, s1, d1, n1);
            end
        end

        chk("gnt_during_busy", gnt_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
